acq_search_controller: RTL

Sequences one subchannel through a serial code-phase acquisition search for a single PRN. For each code-phase hypothesis, the controller:
- seeks the C/A upsampler to the target shift;
- clears the track accumulator;
- integrates a fixed number of sample strobes;
- waits out the accumulation pipeline;
- compares the accumulator magnitude against the running best.

It sits between the channel-level host logic and one subchannel. It drives the subchannel's `prn`, `seek_en`, `seek_target` and `reset`, and reads back the subchannel's `accumulator`.

---
 rtl/acq_search_controller_if.sv | 35 +++
 rtl/acq_search_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/acq_search_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : acq_search_controller_if
// Brief    : Host and subchannel signal bundle for the acquisition search
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
interface acq_search_controller_if;
    // host side
    logic        start;
    logic        abort;
    logic [4:0]  prn_in;
    logic        busy;
    logic        done;
    logic [14:0] best_shift;
    logic [18:0] best_mag;
    // subchannel side
    logic        data_available;
    logic [18:0] accumulator;
    logic [4:0]  prn;
    logic        seek_en;
    logic [14:0] seek_target;
    logic        sub_reset;

    modport master (
        input  start, abort, prn_in, data_available, accumulator,
        output prn, seek_en, seek_target, sub_reset, busy, done, best_shift, best_mag
    );

    modport slave (
        output start, abort, prn_in, data_available, accumulator,
        input  prn, seek_en, seek_target, sub_reset, busy, done, best_shift, best_mag
    );
endinterface
`default_nettype wire

// File: rtl/acq_search_controller.sv
`default_nettype none
// ============================================================================
// Module   : acq_search_controller
// Brief    : Serial code-phase search for one PRN on one subchannel; tracks
//            the shift with the largest accumulator magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module acq_search_controller #(
    parameter int CODE_SHIFT_MAX = 16367,
    parameter int STEP           = 8,
    parameter int INT_SAMPLES    = 16368,
    parameter int SEEK_WAIT      = 4,
    parameter int PIPE_DELAY     = 6
) (
    input  wire                      clk,
    input  wire                      reset,
    acq_search_controller_if.master  bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEEK      = 3'd1;
    localparam logic [2:0] S_SETTLE    = 3'd2;
    localparam logic [2:0] S_CLEAR     = 3'd3;
    localparam logic [2:0] S_INTEGRATE = 3'd4;
    localparam logic [2:0] S_DRAIN     = 3'd5;
    localparam logic [2:0] S_COMPARE   = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam int WAIT_MAX = (SEEK_WAIT > PIPE_DELAY) ? SEEK_WAIT : PIPE_DELAY;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int STROBE_W = $clog2(INT_SAMPLES + 1);

    localparam logic [WAIT_W-1:0]   c_seek_last = WAIT_W'(SEEK_WAIT - 1);
    localparam logic [WAIT_W-1:0]   c_pipe_last = WAIT_W'(PIPE_DELAY - 1);
    localparam logic [STROBE_W-1:0] c_int_last  = STROBE_W'(INT_SAMPLES - 1);
    localparam logic [15:0]         c_step      = 16'(STEP);
    localparam logic [15:0]         c_shift_max = 16'(CODE_SHIFT_MAX);

    logic [2:0]          r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [STROBE_W-1:0] r_strobe_cnt;
    logic [14:0]         r_shift;
    logic [4:0]          r_prn;
    logic                r_seek_en;
    logic                r_sub_reset;
    logic                r_busy;
    logic                r_done;
    logic [14:0]         r_best_shift;
    logic [18:0]         r_best_mag;

    logic [2:0]  w_next;
    logic [18:0] w_neg;
    logic [18:0] w_mag;
    logic [15:0] w_shift_sum;
    logic        w_last_hyp;

    // |accumulator|; the single unrepresentable negation saturates
    always_comb begin
        w_neg = ~bus.accumulator + 19'd1;
        if (!bus.accumulator[18])
            w_mag = bus.accumulator;
        else if (bus.accumulator == 19'h40000)
            w_mag = 19'h3FFFF;
        else
            w_mag = w_neg;
    end

    assign w_shift_sum = {1'b0, r_shift} + c_step;
    assign w_last_hyp  = (w_shift_sum > c_shift_max);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (bus.start) w_next = S_SEEK;
            S_SEEK:      w_next = S_SETTLE;
            S_SETTLE:    if (r_wait_cnt == c_seek_last) w_next = S_CLEAR;
            S_CLEAR:     w_next = S_INTEGRATE;
            S_INTEGRATE: if (bus.data_available && (r_strobe_cnt == c_int_last)) w_next = S_DRAIN;
            S_DRAIN:     if (r_wait_cnt == c_pipe_last) w_next = S_COMPARE;
            S_COMPARE:   w_next = w_last_hyp ? S_DONE : S_SEEK;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (bus.abort && (r_state != S_IDLE))
            w_next = S_IDLE;
    end

    // Pulse outputs are decoded from the next state so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_strobe_cnt <= '0;
            r_shift      <= '0;
            r_prn        <= '0;
            r_seek_en    <= 1'b0;
            r_sub_reset  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_best_shift <= '0;
            r_best_mag   <= '0;
        end else begin
            r_state     <= w_next;
            r_busy      <= (w_next != S_IDLE);
            r_seek_en   <= (w_next == S_SEEK);
            r_sub_reset <= (w_next == S_CLEAR);
            r_done      <= (w_next == S_DONE);

            if (r_state != w_next)
                r_wait_cnt <= '0;
            else
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);

            if (r_state == S_CLEAR)
                r_strobe_cnt <= '0;
            else if ((r_state == S_INTEGRATE) && bus.data_available)
                r_strobe_cnt <= r_strobe_cnt + STROBE_W'(1);

            if ((r_state == S_IDLE) && bus.start) begin
                r_prn        <= bus.prn_in;
                r_shift      <= '0;
                r_best_shift <= '0;
                r_best_mag   <= '0;
            end

            if ((r_state == S_COMPARE) && !bus.abort) begin
                if (w_mag > r_best_mag) begin
                    r_best_mag   <= w_mag;
                    r_best_shift <= r_shift;
                end
                if (!w_last_hyp)
                    r_shift <= w_shift_sum[14:0];
            end
        end
    end

    assign bus.prn         = r_prn;
    assign bus.seek_en     = r_seek_en;
    assign bus.seek_target = r_shift;
    assign bus.sub_reset   = r_sub_reset;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.best_shift  = r_best_shift;
    assign bus.best_mag    = r_best_mag;

endmodule
`default_nettype wire
